// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// The captured instruction fields are registered. Operands are resolved
// combinationally from those registered fields and the current bypass buses.
module id_ex_operand_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OPCODE_LENGTH  = 4,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_alu_src_imm,
    input  logic                      id_alu_src_pc,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_ctrl,
    input  logic                      id_reg_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     operand_a,
    output logic [DATA_WIDTH-1:0]     operand_b,
    output logic [OPCODE_LENGTH-1:0]  alu_ctrl,
    output logic                      ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic [DATA_WIDTH-1:0]     ex_store_data
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = REG_ADDR_WIDTH'(0);

    logic                      valid_q,       valid_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q,    rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q,    rs2_data_d;
    logic [DATA_WIDTH-1:0]     imm_q,         imm_d;
    logic [DATA_WIDTH-1:0]     pc_q,          pc_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q,    rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q,    rs2_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,     rd_addr_d;
    logic                      alu_src_imm_q, alu_src_imm_d;
    logic                      alu_src_pc_q,  alu_src_pc_d;
    logic [OPCODE_LENGTH-1:0]  alu_ctrl_q,    alu_ctrl_d;
    logic                      reg_write_q,   reg_write_d;

    logic                  memwb_live;
    logic                  exmem_live;
    logic [DATA_WIDTH-1:0] fwd1;
    logic [DATA_WIDTH-1:0] fwd2;

    // A bypass source is meaningful only when it writes a nonzero register
    assign memwb_live = memwb_reg_write && (memwb_rd != REG_ZERO);
    assign exmem_live = exmem_reg_write && (exmem_rd != REG_ZERO);

    // Next-state selection: flush > stall > load (reset handled in the register)
    always_comb begin
        valid_d       = valid_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rd_addr_d     = rd_addr_q;
        alu_src_imm_d = alu_src_imm_q;
        alu_src_pc_d  = alu_src_pc_q;
        alu_ctrl_d    = alu_ctrl_q;
        reg_write_d   = reg_write_q;

        if (flush) begin
            // Bubble: only the fields that make it architecturally inert
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            alu_ctrl_d  = '0;
        end else if (stall) begin
            // A producer retiring while we wait would otherwise be lost
            if (memwb_live && (memwb_rd == rs1_addr_q)) rs1_data_d = memwb_result;
            if (memwb_live && (memwb_rd == rs2_addr_q)) rs2_data_d = memwb_result;
        end else begin
            valid_d       = id_valid;
            rs1_data_d    = (memwb_live && (memwb_rd == id_rs1_addr)) ? memwb_result : id_rs1_data;
            rs2_data_d    = (memwb_live && (memwb_rd == id_rs2_addr)) ? memwb_result : id_rs2_data;
            imm_d         = id_imm;
            pc_d          = id_pc;
            rs1_addr_d    = id_rs1_addr;
            rs2_addr_d    = id_rs2_addr;
            rd_addr_d     = id_rd_addr;
            alu_src_imm_d = id_alu_src_imm;
            alu_src_pc_d  = id_alu_src_pc;
            alu_ctrl_d    = id_alu_ctrl;
            reg_write_d   = id_reg_write && id_valid;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            alu_src_imm_q <= 1'b0;
            alu_src_pc_q  <= 1'b0;
            alu_ctrl_q    <= '0;
            reg_write_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_addr_q     <= rd_addr_d;
            alu_src_imm_q <= alu_src_imm_d;
            alu_src_pc_q  <= alu_src_pc_d;
            alu_ctrl_q    <= alu_ctrl_d;
            reg_write_q   <= reg_write_d;
        end
    end

    // Forwarding mux: youngest producer (EX/MEM) wins, x0 is never bypassed
    always_comb begin
        fwd1 = rs1_data_q;
        fwd2 = rs2_data_q;
        if (exmem_live && (exmem_rd == rs1_addr_q))      fwd1 = exmem_result;
        else if (memwb_live && (memwb_rd == rs1_addr_q)) fwd1 = memwb_result;
        if (exmem_live && (exmem_rd == rs2_addr_q))      fwd2 = exmem_result;
        else if (memwb_live && (memwb_rd == rs2_addr_q)) fwd2 = memwb_result;
    end

    // ALU-facing outputs; data buses are zeroed for a bubble
    always_comb begin
        operand_a     = '0;
        operand_b     = '0;
        ex_store_data = '0;
        if (valid_q) begin
            operand_a     = alu_src_pc_q  ? pc_q  : fwd1;
            operand_b     = alu_src_imm_q ? imm_q : fwd2;
            ex_store_data = fwd2;
        end
    end

    assign alu_ctrl     = alu_ctrl_q;
    assign ex_valid     = valid_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q && valid_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding network, directly upstream of the ALU.
- Captures decoded operands and control from ID each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives operand_a, operand_b and alu_ctrl to the ALU; also drives the rd/write-enable sideband that travels with the instruction.

Parameters:
DATA_WIDTH, 32, datapath width
OPCODE_LENGTH, 4, ALU control width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
stall  input  1  hold current EX contents
flush  input  1  replace EX contents with bubble
id_valid  input  1  ID holds a real instruction
id_rs1_data  input  DATA_WIDTH  regfile read port 1
id_rs2_data  input  DATA_WIDTH  regfile read port 2
id_imm  input  DATA_WIDTH  sign-extended immediate
id_pc  input  DATA_WIDTH  instruction PC
id_rs1_addr  input  REG_ADDR_WIDTH  source 1 index
id_rs2_addr  input  REG_ADDR_WIDTH  source 2 index
id_rd_addr  input  REG_ADDR_WIDTH  destination index
id_alu_src_imm  input  1  operand_b = imm
id_alu_src_pc  input  1  operand_a = pc
id_alu_ctrl  input  OPCODE_LENGTH  ALU operation
id_reg_write  input  1  instruction writes rd
exmem_reg_write  input  1  EX/MEM writes back
exmem_rd  input  REG_ADDR_WIDTH  EX/MEM destination
exmem_result  input  DATA_WIDTH  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writes regfile this cycle
memwb_rd  input  REG_ADDR_WIDTH  MEM/WB destination
memwb_result  input  DATA_WIDTH  MEM/WB write data
operand_a  output  DATA_WIDTH  ALU operand A
operand_b  output  DATA_WIDTH  ALU operand B
alu_ctrl  output  OPCODE_LENGTH  ALU operation
ex_valid  output  1  EX holds a real instruction
ex_rd_addr  output  REG_ADDR_WIDTH  destination carried forward
ex_reg_write  output  1  gated by ex_valid
ex_store_data  output  DATA_WIDTH  forwarded rs2 value, for stores

Behaviour:
Clock and reset:
- One clock: clk. reset is synchronous, active-high.
- Reset: all internal registers cleared. ex_valid=0, alu_ctrl=0, ex_rd_addr=0, ex_reg_write=0; operand_a, operand_b and ex_store_data read 0.
- Reset mid-stall or mid-flush discards all contents.

Register update (priority reset > flush > stall > load):
- flush: next-state valid=0, reg_write=0, alu_ctrl=0; other fields don't-care. Flush wins over stall.
- stall: all fields hold.
- Exception during stall: if memwb_reg_write and memwb_rd!=0 and memwb_rd equals the held rs1 (rs2), the held rs1 (rs2) data register is overwritten with memwb_result. This keeps a stalled instruction correct after the producer retires.
- load: capture all id_* fields. ex_reg_write register = id_reg_write & id_valid.
- Write-through on capture: if memwb_reg_write, memwb_rd!=0 and memwb_rd==id_rs1_addr (rs2), capture memwb_result instead of id_rs1_data (id_rs2_data). This covers a regfile write in the same cycle as the read.
- Latency: ID fields appear at the outputs one cycle after capture.

Forwarding (combinational, from registered fields):
- fwd1 = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs1.
- Else fwd1 = memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs1.
- Else fwd1 = registered rs1 data.
- fwd2 is formed the same way for rs2.
- EX/MEM has priority over MEM/WB. rs==0 is never forwarded.
- operand_a = alu_src_pc ? pc : fwd1.
- operand_b = alu_src_imm ? imm : fwd2.
- ex_store_data = fwd2 regardless of alu_src_imm.
- When ex_valid=0: operand_a, operand_b and ex_store_data are forced to 0, and ex_reg_write=0.

Out of scope:
- Load-use hazard detection; the hazard unit drives stall/flush.

Test Plan:
- Reset with all id_* inputs nonzero -> every output 0 on the next edge; ex_valid=0.
- id_rs1_data=5, id_rs2_data=7, alu_ctrl=0000, no forwarding -> next cycle operand_a=5, operand_b=7, alu_ctrl=0000, ex_valid=1.
- Held rs1=3. exmem_rd=3/result=0x10 and memwb_rd=3/result=0x20, both writing -> operand_a=0x10. Drop exmem_reg_write -> operand_a=0x20. Repeat with rs1=0 -> operand_a = registered value 0, never forwarded.
- Stall 3 cycles with held rs2=4 while memwb writes x4=0xAB -> during the stall operand_b=0xAB. After MEM/WB goes idle, still operand_b=0xAB (data register was updated).
- stall=1 and flush=1 together -> ex_valid=0, alu_ctrl=0, ex_reg_write=0, operand_a=0.
- id_alu_src_pc=1, id_alu_src_imm=1, pc=0x100, imm=0xFFFFFFFC, forwarded rs2=0x55 -> operand_a=0x100, operand_b=0xFFFFFFFC, ex_store_data=0x55.
